// File: rtl/hamming_serial_decoder.sv
// Serial-in Hamming(2^P-1, 2^P-1-P) receiver/decoder: LSB-first bit capture, syndrome, single-bit correction.
// Optional SECDED mode (extra overall-parity bit, double-error flag) enabled by `define HAMMING_DEC_SECDED_EN.
module hamming_serial_decoder #(
    parameter int  PARITY_BITS = 4,
    localparam int CODE_WIDTH  = (1 << PARITY_BITS) - 1,
    localparam int DATA_WIDTH  = CODE_WIDTH - PARITY_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   serial_in,
    input  logic                   serial_valid,
    output logic                   serial_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [PARITY_BITS-1:0] syndrome,
    output logic                   error_corrected,
    output logic                   double_error,
    output logic [1:0]             state_dbg
);

`ifdef HAMMING_DEC_SECDED_EN
    localparam int FRAME_W = CODE_WIDTH + 1;
`else
    localparam int FRAME_W = CODE_WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_W + 1);

    // Handshakes: a bit moves when serial_valid && serial_ready at a rising edge;
    // a word moves when data_valid && data_ready at a rising edge.
    typedef enum logic [1:0] {
        ST_RECV  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [PARITY_BITS-1:0] syn_q, syn_d;
    logic                   ec_q, ec_d;
    logic                   de_q, de_d;
    logic                   valid_q, valid_d;

    logic [PARITY_BITS-1:0] syn_calc;
    logic                   ec_calc;
    logic                   de_calc;
    logic [CODE_WIDTH-1:0]  code_fix;
    logic [DATA_WIDTH-1:0]  data_calc;
    logic                   accept;
`ifdef HAMMING_DEC_SECDED_EN
    logic                   overall_odd;
`endif

    assign serial_ready    = (state_q == ST_RECV);
    assign accept          = serial_valid && serial_ready;
    assign data_out        = data_q;
    assign data_valid      = valid_q;
    assign syndrome        = syn_q;
    assign error_corrected = ec_q;
    assign double_error    = de_q;
    assign state_dbg       = state_q;

    always_comb begin : decode
        syn_calc = '0;
        for (int k = 1; k <= CODE_WIDTH; k++) begin
            if (shift_q[PARITY_BITS'(k - 1)]) begin
                syn_calc = syn_calc ^ PARITY_BITS'(k);
            end
        end
`ifdef HAMMING_DEC_SECDED_EN
        overall_odd = ^shift_q;
        // Even overall parity with a nonzero syndrome means two flips: report, do not correct.
        de_calc     = (syn_calc != '0) && !overall_odd;
        ec_calc     = overall_odd;
`else
        de_calc     = 1'b0;
        ec_calc     = (syn_calc != '0);
`endif
        code_fix = shift_q[CODE_WIDTH-1:0];
        for (int k = 1; k <= CODE_WIDTH; k++) begin
            if (ec_calc && (syn_calc == PARITY_BITS'(k))) begin
                code_fix[PARITY_BITS'(k - 1)] = ~code_fix[PARITY_BITS'(k - 1)];
            end
        end
        // Walk positions downward so the lowest data position ends up in data bit 0.
        data_calc = '0;
        for (int k = CODE_WIDTH; k >= 1; k--) begin
            if ((k & (k - 1)) != 0) begin
                data_calc = {data_calc[DATA_WIDTH-2:0], code_fix[PARITY_BITS'(k - 1)]};
            end
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        data_d  = data_q;
        syn_d   = syn_q;
        ec_d    = ec_q;
        de_d    = de_q;
        valid_d = valid_q;

        case (state_q)
            ST_RECV: begin
                if (accept) begin
                    shift_d = {serial_in, shift_q[FRAME_W-1:1]};
                    if (count_q == CNT_W'(FRAME_W - 1)) begin
                        count_d = '0;
                        state_d = ST_CHECK;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                data_d  = data_calc;
                syn_d   = syn_calc;
                ec_d    = ec_calc;
                de_d    = de_calc;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (data_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_RECV;
                end
            end
            default: begin
                valid_d = 1'b0;
                count_d = '0;
                state_d = ST_RECV;
            end
        endcase

        if (clear) begin
            state_d = ST_RECV;
            count_d = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RECV;
            count_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            syn_q   <= '0;
            ec_q    <= 1'b0;
            de_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            syn_q   <= syn_d;
            ec_q    <= ec_d;
            de_q    <= de_d;
            valid_q <= valid_d;
        end
    end

endmodule
